and_gate_checker: RTL and testbench
===================================

Name: and_gate_checker

Overview:
Self-checking response monitor that sits directly downstream of the 2-input AND gate. It observes the gate's inputs a, b and its output y. After each input change it waits a settle window, then compares y against a & b. It counts passes and failures, records which of the four input combinations have been verified, and flags mismatches for the bench or a top-level status LED.

Parameters:
SETTLE_CYCLES, 2, clock cycles the inputs must stay stable before y is checked (legal range 1..255)
CNT_W, 8, width of the pass and fail counters

Ports:
clk  input  1  system clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  monitor enable; 0 forces IDLE, counters hold
clr  input  1  synchronous clear of counters, coverage, error and FSM (same effect as rst, lower priority)
a  input  1  gate input a (same net as driven into the gate)
b  input  1  gate input b
y  input  1  gate output under check
pass_cnt  output  CNT_W  number of passing checks, saturating
fail_cnt  output  CNT_W  number of failing checks, saturating
coverage  output  4  bit {a,b} set once that combination has passed
all_covered  output  1  &coverage
mismatch  output  1  one-cycle pulse on a failing check
error  output  1  sticky, set on first failure
fail_ab  output  2  {a,b} of the most recent failing check
busy  output  1  high in SETTLE or CHECK

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Priority: rst > clr > en. rst or clr at an edge gives state IDLE.
- Values after rst or clr: pass_cnt=0, fail_cnt=0, coverage=0, error=0, mismatch=0, fail_ab=0, cap_ab=0, settle counter=0.
- All outputs are registered, except all_covered and busy, which are decoded from registers.
- Internal registers: cap_ab (2 bits, the captured {a,b}) and cnt (8 bits).
- en=0 at any edge: next state IDLE. Counters, coverage and error hold. mismatch=0.
- IDLE: if en=1, capture cap_ab={a,b}, set cnt=0 and go to SETTLE. The first check after enable therefore needs no input change.
- SETTLE, inputs changed ({a,b}!=cap_ab): recapture cap_ab, set cnt=0 and stay in SETTLE. This is a glitch restart and is not counted.
- SETTLE, inputs stable and cnt==SETTLE_CYCLES-1: go to CHECK.
- SETTLE, inputs stable otherwise: cnt++.
- CHECK, inputs changed ({a,b}!=cap_ab): abort. Recapture, set cnt=0, go to SETTLE. No counter update.
- CHECK, y==(cap_ab[1]&cap_ab[0]) (pass): pass_cnt++ and coverage[cap_ab]=1.
- CHECK, otherwise (fail): fail_cnt++, mismatch=1 for exactly this one cycle, error=1, fail_ab=cap_ab.
- After a completed pass or fail in CHECK, go to WAIT_CHG.
- WAIT_CHG: on {a,b}!=cap_ab, recapture, set cnt=0 and go to SETTLE. Otherwise stay. A held input pattern is checked only once.
- Latency: the first edge that samples new inputs is edge E0. The counter, coverage and mismatch update is visible after edge E0+SETTLE_CYCLES+1. If inputs stay stable, the next check needs an input change.
- Saturation: pass_cnt and fail_cnt stop at 2^CNT_W-1. No wrap.
- Sticky status: error and coverage clear only on rst or clr.
- Reset mid-operation: rst or clr during SETTLE or CHECK discards the pending check. No count and no mismatch on that edge.
- Inputs a, b and y are assumed synchronous to clk. The bench drives them on the negedge or via registers. Asynchronous stimulus is handled by the glitch-restart rule, never by metastability logic.

Test Plan:
1. Reset clears outputs: SETTLE_CYCLES=2. Hold rst=1 for 2 edges with a=1, b=1 and en=1 → all outputs 0 and busy=0.
2. Enable gives one pass: release rst with {a,b}=11 and y=1 held → after edge 3 pass_cnt=1 and coverage=4'b1000. Hold 10 more cycles → pass_cnt stays 1.
3. Exhaustive sweep with a correct gate: step {a,b} through 00, 01, 10, 11, each held 6 cycles → pass_cnt=4, coverage=4'hF, all_covered=1, fail_cnt=0, error=0.
4. Fault injection: force y=0 while {a,b}=11 → exactly one mismatch pulse, fail_cnt=1, error=1, fail_ab=2'b11. Then clr=1 for 1 cycle → all outputs 0 and error=0.
5. Glitch restart: toggle a every cycle for 5 cycles, then hold → no check during toggling. One check happens SETTLE_CYCLES+1 edges after the last change. A toggle in the CHECK cycle aborts with no count.
6. Saturation and en gating: CNT_W=2 with 5 passing changes → pass_cnt=3. Drop en mid-SETTLE → busy=0 next cycle and no count. Re-enable → fresh check.

Source files
------------

// File: rtl/and_gate_checker.sv
// and_gate_checker
//   Response monitor for a 2-input AND gate. After each change on {a,b} the
//   inputs must stay stable for SETTLE_CYCLES clocks. y is then compared
//   against a & b. Passes, failures and the set of verified input
//   combinations are recorded.
//
// Ports
//   clk          system clock, rising edge
//   rst          synchronous active-high reset
//   en           monitor enable (0 forces IDLE; counters/coverage/error hold)
//   clr          synchronous clear, same effect as rst, lower priority
//   a, b         gate inputs
//   y            gate output under check
//   pass_cnt     saturating count of passing checks
//   fail_cnt     saturating count of failing checks
//   coverage     bit {a,b} set once that combination has passed
//   all_covered  &coverage
//   mismatch     one-cycle pulse on a failing check
//   error        sticky failure flag
//   fail_ab      {a,b} of the most recent failing check
//   busy         high while a check is pending (SETTLE or CHECK)
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | monitor disabled, or just reset/cleared
// SETTLE   | inputs captured in cap_ab, counting stable cycles in cnt
// CHECK    | inputs stable long enough, compare y on this edge
// WAIT_CHG | pattern already checked, waiting for {a,b} to change

module and_gate_checker #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic             a,
  input  logic             b,
  input  logic             y,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       coverage,
  output logic             all_covered,
  output logic             mismatch,
  output logic             error,
  output logic [1:0]       fail_ab,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SETTLE   = 2'd1,
    CHECK    = 2'd2,
    WAIT_CHG = 2'd3
  } state_t;

  localparam logic [7:0]       SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX     = '1;

  state_t           state, state_nxt;
  logic [1:0]       cap_ab, cap_ab_nxt;
  logic [7:0]       cnt, cnt_nxt;
  logic [CNT_W-1:0] pass_cnt_nxt, fail_cnt_nxt;
  logic [3:0]       coverage_nxt;
  logic             mismatch_nxt, error_nxt;
  logic [1:0]       fail_ab_nxt;

  logic [1:0] ab;
  logic       changed;

  assign ab      = {a, b};
  assign changed = (ab != cap_ab);

  always_comb begin
    state_nxt    = state;
    cap_ab_nxt   = cap_ab;
    cnt_nxt      = cnt;
    pass_cnt_nxt = pass_cnt;
    fail_cnt_nxt = fail_cnt;
    coverage_nxt = coverage;
    mismatch_nxt = 1'b0;
    error_nxt    = error;
    fail_ab_nxt  = fail_ab;

    if (!en) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          // capture unconditionally so the first check needs no input change
          cap_ab_nxt = ab;
          cnt_nxt    = 8'd0;
          state_nxt  = SETTLE;
        end
        SETTLE: begin
          if (changed) begin
            cap_ab_nxt = ab;
            cnt_nxt    = 8'd0;
          end else if (cnt == SETTLE_LAST) begin
            state_nxt = CHECK;
          end else begin
            cnt_nxt = cnt + 8'd1;
          end
        end
        CHECK: begin
          if (changed) begin
            // late change aborts the check without counting it
            cap_ab_nxt = ab;
            cnt_nxt    = 8'd0;
            state_nxt  = SETTLE;
          end else if (y == (cap_ab[1] & cap_ab[0])) begin
            if (pass_cnt != CNT_MAX) pass_cnt_nxt = pass_cnt + 1'b1;
            coverage_nxt[cap_ab] = 1'b1;
            state_nxt = WAIT_CHG;
          end else begin
            if (fail_cnt != CNT_MAX) fail_cnt_nxt = fail_cnt + 1'b1;
            mismatch_nxt = 1'b1;
            error_nxt    = 1'b1;
            fail_ab_nxt  = cap_ab;
            state_nxt    = WAIT_CHG;
          end
        end
        WAIT_CHG: begin
          if (changed) begin
            cap_ab_nxt = ab;
            cnt_nxt    = 8'd0;
            state_nxt  = SETTLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state    <= IDLE;
      cap_ab   <= 2'b00;
      cnt      <= 8'd0;
      pass_cnt <= '0;
      fail_cnt <= '0;
      coverage <= 4'b0000;
      mismatch <= 1'b0;
      error    <= 1'b0;
      fail_ab  <= 2'b00;
    end else begin
      state    <= state_nxt;
      cap_ab   <= cap_ab_nxt;
      cnt      <= cnt_nxt;
      pass_cnt <= pass_cnt_nxt;
      fail_cnt <= fail_cnt_nxt;
      coverage <= coverage_nxt;
      mismatch <= mismatch_nxt;
      error    <= error_nxt;
      fail_ab  <= fail_ab_nxt;
    end
  end

  assign all_covered = &coverage;
  assign busy        = (state == SETTLE) || (state == CHECK);

endmodule

// File: tb/tb_and_gate_checker.sv
// Bench for and_gate_checker: directed scenarios followed by random stimulus.
// Two instances share all inputs; u_sat uses a 2-bit counter width to show
// saturation. A behavioural model tracks how long the current pattern has
// been stable and whether it was already checked.

module tb_and_gate_checker;

  localparam int S = 2;

  logic clk = 1'b0;
  logic rst, en, clr, a, b, y;

  logic [7:0] pass_cnt, fail_cnt;
  logic [3:0] coverage;
  logic       all_covered, mismatch, error, busy;
  logic [1:0] fail_ab;

  logic [1:0] s_pass_cnt, s_fail_cnt;
  logic [3:0] s_coverage;
  logic       s_all_covered, s_mismatch, s_error, s_busy;
  logic [1:0] s_fail_ab;

  and_gate_checker #(.SETTLE_CYCLES(S), .CNT_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .y(y),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .coverage(coverage),
    .all_covered(all_covered), .mismatch(mismatch), .error(error),
    .fail_ab(fail_ab), .busy(busy)
  );

  and_gate_checker #(.SETTLE_CYCLES(S), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .clr(clr), .a(a), .b(b), .y(y),
    .pass_cnt(s_pass_cnt), .fail_cnt(s_fail_cnt), .coverage(s_coverage),
    .all_covered(s_all_covered), .mismatch(s_mismatch), .error(s_error),
    .fail_ab(s_fail_ab), .busy(s_busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
  endtask

  // reference model
  bit         m_active, m_done, m_err, m_mm;
  logic [1:0] m_cap, m_fab;
  int         m_age, m_pass, m_fail;
  logic [3:0] m_cov;

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_edge();
    m_mm = 1'b0;
    if (rst || clr) begin
      m_active = 0; m_done = 0; m_cap = 2'b00; m_age = 0;
      m_pass = 0; m_fail = 0; m_cov = 4'b0; m_err = 0; m_fab = 2'b00;
    end else if (!en) begin
      m_active = 0;
    end else if (!m_active || {a, b} != m_cap) begin
      m_active = 1; m_done = 0; m_cap = {a, b}; m_age = 0;
    end else if (!m_done) begin
      m_age++;
      if (m_age == S + 1) begin
        m_done = 1;
        if (y == (m_cap == 2'b11)) begin
          m_pass++;
          m_cov[m_cap] = 1'b1;
        end else begin
          m_fail++;
          m_mm  = 1'b1;
          m_err = 1'b1;
          m_fab = m_cap;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("pass_cnt",    pass_cnt,    sat(m_pass, 8));
    chk("fail_cnt",    fail_cnt,    sat(m_fail, 8));
    chk("coverage",    coverage,    m_cov);
    chk("all_covered", all_covered, &m_cov);
    chk("mismatch",    mismatch,    m_mm);
    chk("error",       error,       m_err);
    chk("fail_ab",     fail_ab,     m_fab);
    chk("busy",        busy,        m_active && !m_done);
    chk("sat_pass_cnt", s_pass_cnt, sat(m_pass, 2));
    chk("sat_fail_cnt", s_fail_cnt, sat(m_fail, 2));
    chk("sat_busy",     s_busy,     m_active && !m_done);
  endtask

  task automatic step(input logic r, input logic c, input logic e,
                      input logic ia, input logic ib, input logic iy);
    @(negedge clk);
    rst = r; clr = c; en = e; a = ia; b = ib; y = iy;
    @(posedge clk);
    model_edge();
    #1 check_all();
  endtask

  task automatic hold(input logic ia, input logic ib, input logic iy, input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1, ia, ib, iy);
  endtask

  initial begin
    logic ra, rb, ry, re, rr, rc;
    rst = 1'b1; clr = 1'b0; en = 1'b1; a = 1'b1; b = 1'b1; y = 1'b1;

    // reset with active inputs
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
    chk("reset_pass", pass_cnt, 0);
    chk("reset_busy", busy, 0);

    // first check after enable, then held pattern is not rechecked
    hold(1'b1, 1'b1, 1'b1, 13);
    chk("held_once", pass_cnt, 1);
    chk("held_cov", coverage, 4'b1000);

    // exhaustive sweep with a correct gate
    for (int p = 0; p < 4; p++) begin
      ra = p[1]; rb = p[0];
      hold(ra, rb, ra & rb, 6);
    end
    chk("sweep_all_covered", all_covered, 1);
    chk("sweep_fail", fail_cnt, 0);

    // fault injection then clear
    hold(1'b0, 1'b0, 1'b0, 6);
    hold(1'b1, 1'b1, 1'b0, 6);
    chk("fault_fail_cnt", fail_cnt, 1);
    chk("fault_fail_ab", fail_ab, 2'b11);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("clr_error", error, 0);

    // glitch restart: toggle a every cycle, then hold
    for (int i = 0; i < 5; i++) begin
      ra = i[0];
      hold(ra, 1'b1, ra, 1);
    end
    hold(1'b1, 1'b1, 1'b1, 6);
    // change landing exactly on the CHECK edge
    hold(1'b0, 1'b1, 1'b0, S + 1);
    hold(1'b1, 1'b0, 1'b0, 6);

    // drop en mid-SETTLE, then re-enable
    hold(1'b0, 1'b0, 1'b0, 1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("en_drop_busy", busy, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    hold(1'b0, 1'b0, 1'b0, 6);

    // saturation of the narrow instance
    for (int i = 0; i < 5; i++) begin
      ra = i[0];
      hold(1'b0, ra, 1'b0, 5);
    end
    chk("sat_pass_3", s_pass_cnt, 3);

    // random phase
    ra = 1'b0; rb = 1'b0; ry = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      rr = ($urandom_range(0, 199) == 0);
      rc = ($urandom_range(0, 149) == 0);
      re = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 3) == 0) begin
        ra = 1'($urandom);
        rb = 1'($urandom);
        ry = (ra & rb) ^ ($urandom_range(0, 7) == 0);
      end else if ($urandom_range(0, 39) == 0) begin
        ry = ~ry;
      end
      step(rr, rc, re, ra, rb, ry);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
